stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 137 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - 4-digit BCD millisecond stopwatch controller; lap hold enabled by STOPWATCH_LAP_EN
module stopwatch_ctrl #(
    parameter int WRAP = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_startStop,
    input  logic        i_clear,
    input  logic        i_lap,
    output logic        o_ce,
    output logic        o_running,
    output logic [15:0] o_digits,
    output logic        o_overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] count;
    logic [15:0] count_nxt;
    logic        ovf_nxt;
    logic        ss_q;
    logic        clr_q;
    logic        ss_rise;
    logic        clr_rise;

    // Any digit at 9 or above rolls to 0, so a corrupt digit can never persist.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign ss_rise  = i_startStop & ~ss_q;
    assign clr_rise = i_clear & ~clr_q;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = o_overflow;
        if (clr_rise) begin
            state_nxt = ST_IDLE;
            count_nxt = 16'h0000;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_rise) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (i_tick) begin
                        if (count == 16'h9999) begin
                            ovf_nxt   = 1'b1;
                            count_nxt = (WRAP != 0) ? 16'h0000 : count;
                        end else begin
                            count_nxt = bcd_inc(count);
                        end
                    end
                    if (ss_rise) state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (ss_rise) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // History registers load 1 so a button held through reset gives no rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            count      <= 16'h0000;
            o_overflow <= 1'b0;
            o_ce       <= 1'b0;
            o_running  <= 1'b0;
            ss_q       <= 1'b1;
            clr_q      <= 1'b1;
        end else begin
            ss_q       <= i_startStop;
            clr_q      <= i_clear;
            state      <= state_nxt;
            count      <= count_nxt;
            o_overflow <= ovf_nxt;
            o_ce       <= (state_nxt == ST_RUN);
            o_running  <= (state_nxt == ST_RUN);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_q;
    logic        lap_rise;
    logic        lap_hold;
    logic [15:0] lap_cnt;

    assign lap_rise = i_lap & ~lap_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lap_q    <= 1'b1;
            lap_hold <= 1'b0;
            lap_cnt  <= 16'h0000;
        end else begin
            lap_q <= i_lap;
            if (clr_rise) begin
                lap_hold <= 1'b0;
            end else if (lap_rise && (state == ST_RUN || state == ST_PAUSE)) begin
                lap_hold <= ~lap_hold;
                lap_cnt  <= count;
            end
        end
    end

    assign o_digits = lap_hold ? lap_cnt : count;
`else
    logic lap_unused;
    assign lap_unused = i_lap;
    assign o_digits   = count;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl, wrapping and saturating instances
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, tick, ss, clr, lap;
    logic        ce_a, run_a, ovf_a, ce_b, run_b, ovf_b;
    logic [15:0] dig_a, dig_b;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.WRAP(1)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_startStop(ss), .i_clear(clr), .i_lap(lap),
        .o_ce(ce_a), .o_running(run_a), .o_digits(dig_a), .o_overflow(ovf_a)
    );

    stopwatch_ctrl #(.WRAP(0)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_startStop(ss), .i_clear(clr), .i_lap(lap),
        .o_ce(ce_b), .o_running(run_b), .o_digits(dig_b), .o_overflow(ovf_b)
    );

    typedef struct {
        string       name;
        logic [15:0] da;
        logic        oa;
        logic [15:0] db;
        logic        ob;
        logic        r;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   checks = 0;
    int   failures = 0;

    initial begin
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                exp_t e;
                logic [39:0] got, req;
                e   = sb.pop_front();
                got = {dig_a, ovf_a, dig_b, ovf_b, ce_a, run_a, ce_b, run_b, 2'b00};
                req = {e.da, e.oa, e.db, e.ob, e.r, e.r, e.r, e.r, 2'b00};
                checks++;
                if (got !== req) begin
                    failures++;
                    $display("FAIL %s: got wrap=%h ovf=%b sat=%h ovf=%b ce/run=%b%b%b%b, required wrap=%h ovf=%b sat=%h ovf=%b ce/run=%b",
                             e.name, dig_a, ovf_a, dig_b, ovf_b, ce_a, run_a, ce_b, run_b,
                             e.da, e.oa, e.db, e.ob, e.r);
                end
            end
        end
    end

    task automatic expect_ab(input string nm, input logic [15:0] da, input logic oa,
                             input logic [15:0] db, input logic ob, input logic r);
        exp_t e;
        e.name = nm; e.da = da; e.oa = oa; e.db = db; e.ob = ob; e.r = r;
        sb.push_back(e);
        -> chk_ev;
        #3;
    endtask

    task automatic expect_both(input string nm, input logic [15:0] d, input logic o, input logic r);
        expect_ab(nm, d, o, d, o, r);
    endtask

    task automatic cyc(input logic t, input logic s, input logic c, input logic l);
        tick = t; ss = s; clr = c; lap = l;
        @(posedge clk); #1;
        tick = 1'b0; ss = 1'b0; clr = 1'b0; lap = 1'b0;
    endtask

    task automatic press(input logic s, input logic c, input logic l);
        cyc(1'b0, s, c, l);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ss = 1'b0; clr = 1'b0; lap = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_both("reset", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        expect_both("start", 16'h0000, 1'b0, 1'b1);
        ticks(25);
        expect_both("run25", 16'h0025, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        expect_both("pause", 16'h0025, 1'b0, 1'b0);
        ticks(10);
        expect_both("pause_ticks", 16'h0025, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(1);
        expect_both("resume", 16'h0026, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        expect_both("clear", 16'h0000, 1'b0, 1'b0);
        ticks(5);
        expect_both("idle_ticks", 16'h0000, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        ticks(100);
        expect_both("pre_lap", 16'h0100, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        expect_both("lap_hold", 16'h0100, 1'b0, 1'b1);
        ticks(50);
        expect_both("lap_50", LAP ? 16'h0100 : 16'h0150, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        expect_both("lap_release", 16'h0150, 1'b0, 1'b1);

        ticks(849);
        expect_both("bcd_0999", 16'h0999, 1'b0, 1'b1);
        ticks(1);
        expect_both("bcd_1000", 16'h1000, 1'b0, 1'b1);
        ticks(8999);
        expect_both("at_9999", 16'h9999, 1'b0, 1'b1);
        ticks(1);
        expect_ab("limit", 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b1);
        ticks(1);
        expect_ab("past_limit", 16'h0001, 1'b1, 16'h9999, 1'b1, 1'b1);

        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        expect_both("clr_ss_tick", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_both("run3", 16'h0003, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        expect_both("tick_ss", 16'h0004, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(2);
        expect_both("run6", 16'h0006, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        expect_both("tick_clr", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        ticks(2);
        expect_both("idle_lap", 16'h0002, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        ticks(3);
        expect_both("hold2", LAP ? 16'h0002 : 16'h0005, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_both("clr_rel_lap", 16'h0003, 1'b0, 1'b1);

        tick = 1'b1; ss = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_both("rst_mid", 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            expect_both("held_ss", 16'h0000, 1'b0, 1'b0);
        end
        ss = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        press(1'b1, 1'b0, 1'b0);
        ticks(1);
        expect_both("after_held", 16'h0001, 1'b0, 1'b1);

        #20;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
